// File: rtl/axis_multi_tone_generator.sv
// Multi-channel AXI-Stream tone source: per-channel phase accumulators, interleaved beats, packet TLAST.
// Optional macro TONE_GEN_SIGNED_EN selects two's-complement samples instead of offset binary.
module axis_multi_tone_generator #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int ACC_WIDTH       = 32,
    parameter int NUM_CHANNELS    = 2,
    parameter int PACKET_SIZE     = 256
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              cfg_enable,
    input  logic [1:0]                        cfg_waveform,
    input  logic [NUM_CHANNELS*ACC_WIDTH-1:0] cfg_increment,
    output logic [AXIS_DATA_WIDTH-1:0]        axis_tdata,
    output logic                              axis_tvalid,
    input  logic                              axis_tready,
    output logic                              axis_tlast,
    output logic [AXIS_KEEP_WIDTH-1:0]        axis_tkeep
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PACKET_SIZE - 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {WAVE_SAW, WAVE_SQUARE, WAVE_TRIANGLE, WAVE_SILENCE} wave_t;

    state_t                     state, state_n;
    wave_t                      wave_l, wave_n;
    logic [ACC_WIDTH-1:0]       acc   [NUM_CHANNELS];
    logic [ACC_WIDTH-1:0]       acc_n [NUM_CHANNELS];
    logic [ACC_WIDTH-1:0]       inc_l [NUM_CHANNELS];
    logic [ACC_WIDTH-1:0]       inc_n [NUM_CHANNELS];
    logic [CH_W-1:0]            ch, ch_n, ch_nx;
    logic [CNT_W-1:0]           cnt, cnt_n, cnt_nx;
    logic [ACC_WIDTH-1:0]       adv, acc_nx;
    logic [AXIS_DATA_WIDTH-1:0] tdata_r, tdata_n;
    logic                       tvalid_r, tvalid_n, tlast_r, tlast_n;

    function automatic logic [AXIS_DATA_WIDTH-1:0] fmt(input logic [ACC_WIDTH-1:0] a,
                                                       input wave_t w);
        logic [SAMPLE_WIDTH-1:0] s;
        logic [SAMPLE_WIDTH-1:0] top;
        logic [SAMPLE_WIDTH-1:0] t;
        top = a[ACC_WIDTH-1 -: SAMPLE_WIDTH];
        t   = a[ACC_WIDTH-2 -: SAMPLE_WIDTH];
        case (w)
            WAVE_SAW:      s = top;
            WAVE_SQUARE:   s = a[ACC_WIDTH-1] ? '1 : '0;
            WAVE_TRIANGLE: s = a[ACC_WIDTH-1] ? ~t : t;
            default:       s = '0;
        endcase
`ifdef TONE_GEN_SIGNED_EN
        s[SAMPLE_WIDTH-1] = ~s[SAMPLE_WIDTH-1];
        fmt = (w == WAVE_SILENCE) ? '0 : AXIS_DATA_WIDTH'($signed(s));
`else
        fmt = AXIS_DATA_WIDTH'(s);
`endif
    endfunction

    always_comb begin
        state_n  = state;
        wave_n   = wave_l;
        acc_n    = acc;
        inc_n    = inc_l;
        ch_n     = ch;
        cnt_n    = cnt;
        tdata_n  = tdata_r;
        tvalid_n = tvalid_r;
        tlast_n  = tlast_r;
        ch_nx    = (ch == LAST_CH) ? '0 : ch + 1'b1;
        cnt_nx   = (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
        adv      = acc[ch] + inc_l[ch];
        acc_nx   = (NUM_CHANNELS == 1) ? adv : acc[ch_nx];

        case (state)
            IDLE: begin
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
                if (cfg_enable) begin
                    // Packets end on a frame boundary, so ch is already 0 here.
                    state_n  = RUN;
                    wave_n   = wave_t'(cfg_waveform);
                    for (int unsigned c = 0; c < NUM_CHANNELS; c++)
                        inc_n[c] = cfg_increment[c*ACC_WIDTH +: ACC_WIDTH];
                    tvalid_n = 1'b1;
                    tdata_n  = fmt(acc[0], wave_t'(cfg_waveform));
                    tlast_n  = (cnt == LAST_BEAT);
                end
            end
            default: begin
                if (tvalid_r && axis_tready) begin
                    acc_n[ch] = adv;
                    ch_n      = ch_nx;
                    cnt_n     = cnt_nx;
                    if (ch == LAST_CH) begin
                        wave_n = wave_t'(cfg_waveform);
                        for (int unsigned c = 0; c < NUM_CHANNELS; c++)
                            inc_n[c] = cfg_increment[c*ACC_WIDTH +: ACC_WIDTH];
                    end
                    if (tlast_r && !cfg_enable) begin
                        state_n  = IDLE;
                        tvalid_n = 1'b0;
                        tlast_n  = 1'b0;
                    end else begin
                        tdata_n = fmt(acc_nx, wave_n);
                        tlast_n = (cnt_nx == LAST_BEAT);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            wave_l   <= WAVE_SAW;
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                acc[c]   <= '0;
                inc_l[c] <= '0;
            end
            ch       <= '0;
            cnt      <= '0;
            tdata_r  <= '0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
        end else begin
            state    <= state_n;
            wave_l   <= wave_n;
            acc      <= acc_n;
            inc_l    <= inc_n;
            ch       <= ch_n;
            cnt      <= cnt_n;
            tdata_r  <= tdata_n;
            tvalid_r <= tvalid_n;
            tlast_r  <= tlast_n;
        end
    end

    assign axis_tdata  = tdata_r;
    assign axis_tvalid = tvalid_r;
    assign axis_tlast  = tlast_r;
    assign axis_tkeep  = '1;

endmodule

// File: tb/tb_axis_multi_tone_generator.sv
// Randomised bench for axis_multi_tone_generator against an arithmetic reference model.
module tb_axis_multi_tone_generator;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int SW = 16;
    localparam int AW = 32;
    localparam int N  = 2;
    localparam int P  = 8;
    localparam longint unsigned HALF = 64'h8000_0000;
    localparam longint unsigned MODA = 64'h1_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn, cfg_enable, axis_tready;
    logic [1:0]    cfg_waveform;
    logic [N*AW-1:0] cfg_increment;
    logic [DW-1:0] axis_tdata;
    logic          axis_tvalid, axis_tlast;
    logic [KW-1:0] axis_tkeep;

    axis_multi_tone_generator #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .SAMPLE_WIDTH(SW),
        .ACC_WIDTH(AW), .NUM_CHANNELS(N), .PACKET_SIZE(P)
    ) dut (
        .clk(clk), .resetn(resetn), .cfg_enable(cfg_enable),
        .cfg_waveform(cfg_waveform), .cfg_increment(cfg_increment),
        .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid),
        .axis_tready(axis_tready), .axis_tlast(axis_tlast), .axis_tkeep(axis_tkeep)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample value (0..65535) as it must appear on the bus.
    function automatic logic [DW-1:0] to_bus(input longint unsigned s);
        longint unsigned v;
`ifdef TONE_GEN_SIGNED_EN
        v = s ^ 64'h8000;
        if (v >= 64'h8000) v = v + 64'hFFFF_0000;
`else
        v = s;
`endif
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] model_sample(input longint unsigned acc, input int w);
        longint unsigned s;
        case (w)
            0: s = acc / 65536;
            1: s = (acc >= HALF) ? 65535 : 0;
            2: begin
                s = (acc / 32768) % 65536;
                if (acc >= HALF) s = 65535 - s;
            end
            default: return '0;
        endcase
        return to_bus(s);
    endfunction

    // Reference model: state as it must be after the most recent clock edge.
    longint unsigned macc [N];
    longint unsigned minc [N];
    int  mwave;
    int  mbeat;
    bit  mrun, mrst, mvalid = 0;
    logic [32:0] log_q[$];

    task automatic capture();
        for (int c = 0; c < N; c++) minc[c] = cfg_increment[c*AW +: AW];
        mwave = cfg_waveform;
    endtask

    always @(negedge clk) begin
        int c;
        bit lastpkt;
        if (mvalid) begin
            check("tvalid", axis_tvalid, mrun);
            check("tkeep", axis_tkeep, 4'hF);
            if (mrun) begin
                check("tdata", axis_tdata, model_sample(macc[mbeat % N], mwave));
                check("tlast", axis_tlast, (mbeat == P - 1));
            end
            if (mrst) begin
                check("rst_tdata", axis_tdata, 0);
                check("rst_tlast", axis_tlast, 0);
            end
            if (axis_tvalid && axis_tready && resetn)
                log_q.push_back({axis_tlast, axis_tdata});
        end
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin macc[i] = 0; minc[i] = 0; end
            mwave = 0; mbeat = 0; mrun = 0; mrst = 1; mvalid = 1;
        end else if (mvalid) begin
            mrst = 0;
            if (!mrun) begin
                if (cfg_enable) begin mrun = 1; capture(); end
            end else if (axis_tready) begin
                c = mbeat % N;
                lastpkt = (mbeat == P - 1);
                macc[c] = (macc[c] + minc[c]) % MODA;
                mbeat = (mbeat + 1) % P;
                if (c == N - 1) capture();
                if (lastpkt && !cfg_enable) mrun = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int target;
        target = log_q.size() + n;
        for (int i = 0; i < budget && log_q.size() < target; i++) step();
        if (log_q.size() < target) check("beat_wait_timeout", 0, 1);
    endtask

    task automatic do_reset();
        resetn = 1'b0; cfg_enable = 1'b0;
        step(); step();
        resetn = 1'b1;
    endtask

    int lit [8] = '{'h0000, 'h0000, 'h0100, 'h0200, 'h0200, 'h0400, 'h0300, 'h0600};
    int s0;

    initial begin
        resetn = 1'b0; cfg_enable = 1'b0; axis_tready = 1'b1;
        cfg_waveform = 2'd0; cfg_increment = '0;
        step(); step(); step();
        resetn = 1'b1;

        // Saw on two channels, free-flowing sink.
        cfg_increment = {32'h0200_0000, 32'h0100_0000};
        log_q.delete();
        cfg_enable = 1'b1;
        wait_beats(24, 100);
        for (int i = 0; i < 8; i++) check("saw_literal", log_q[i][31:0], to_bus(lit[i]));
        check("tlast_beat6", log_q[6][32], 0);
        check("tlast_beat7", log_q[7][32], 1);
        check("tlast_beat15", log_q[15][32], 1);
        check("tlast_beat23", log_q[23][32], 1);

        // Stop request after beat 3: packet completes, then valid drops.
        wait_beats(4, 20);
        cfg_enable = 1'b0;
        s0 = log_q.size();
        for (int i = 0; i < 20 && axis_tvalid; i++) step();
        check("stop_beats", log_q.size() - s0, 4);
        check("stop_tlast", log_q[log_q.size()-1][32], 1);
        step(); step();
        cfg_enable = 1'b1;
        wait_beats(8, 40);

        // Random backpressure, config changes, stop requests and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            axis_tready = ($urandom_range(1, 0) == 1);
            if ($urandom_range(7, 0) == 0) cfg_enable = ($urandom_range(5, 0) != 0);
            if ($urandom_range(15, 0) == 0) cfg_waveform = 2'($urandom_range(3, 0));
            if ($urandom_range(15, 0) == 0)
                cfg_increment = {32'($urandom), 32'($urandom)};
            resetn = ($urandom_range(300, 0) != 0);
            step();
        end
        resetn = 1'b1; axis_tready = 1'b1;

        // Reset mid-packet, then restart from zero phase.
        do_reset();
        cfg_waveform = 2'd0;
        cfg_increment = {32'h0200_0000, 32'h0100_0000};
        cfg_enable = 1'b1;
        wait_beats(5, 20);
        resetn = 1'b0; cfg_enable = 1'b0;
        step();
        resetn = 1'b1;
        log_q.delete();
        cfg_enable = 1'b1;
        wait_beats(8, 30);
        check("restart_first", log_q[0][31:0], to_bus(0));
        check("restart_tlast6", log_q[6][32], 0);
        check("restart_tlast7", log_q[7][32], 1);

        // Triangle: ch0 at acc 0x80000000 -> 0xFFFF, 0xC0000000 -> 0x7FFF.
        do_reset();
        cfg_waveform = 2'd2;
        cfg_increment = {32'h0000_0000, 32'h4000_0000};
        log_q.delete();
        cfg_enable = 1'b1;
        wait_beats(8, 30);
        check("tri_frame1", log_q[2][31:0], to_bus('h8000));
        check("tri_frame2", log_q[4][31:0], to_bus('hFFFF));
        check("tri_frame3", log_q[6][31:0], to_bus('h7FFF));

        // Square at half-rate on ch0 alternates.
        do_reset();
        cfg_waveform = 2'd1;
        cfg_increment = {32'h0000_0000, 32'h8000_0000};
        log_q.delete();
        cfg_enable = 1'b1;
        wait_beats(6, 30);
        check("sq_frame0", log_q[0][31:0], to_bus(0));
        check("sq_frame1", log_q[2][31:0], to_bus('hFFFF));
        check("sq_frame2", log_q[4][31:0], to_bus(0));

        cfg_enable = 1'b0;
        repeat (20) step();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/axis_multi_tone_generator.md
Name: axis_multi_tone_generator

Overview:
- Multi-channel, multi-waveform successor to the fixed single-tone AXI-Stream source.
- Runs one phase accumulator per channel, each with its own runtime increment. Channels are interleaved onto one AXIS master, one beat per channel per frame.
- Supports sawtooth, square, triangle and silence waveforms.
- Generates correct packet TLAST and a clean start/stop gate, so the downstream DMA always receives whole packets.

Parameters:
- AXIS_DATA_WIDTH, 32, TDATA width; must be >= SAMPLE_WIDTH.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, TKEEP width.
- SAMPLE_WIDTH, 16, bits per sample; must be <= ACC_WIDTH-1.
- ACC_WIDTH, 32, phase accumulator width.
- NUM_CHANNELS, 2, interleaved channels (1..8).
- PACKET_SIZE, 256, beats per packet; must be a multiple of NUM_CHANNELS.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  synchronous, active-low reset.
- cfg_enable  in  1  run/stop request.
- cfg_waveform  in  2  0 saw, 1 square, 2 triangle, 3 silence.
- cfg_increment  in  NUM_CHANNELS*ACC_WIDTH  per-channel phase step; channel c is slice [c*ACC_WIDTH +: ACC_WIDTH].
- axis_tdata  out  AXIS_DATA_WIDTH  sample, in low SAMPLE_WIDTH bits.
- axis_tvalid  out  1  beat valid.
- axis_tready  in  1  downstream ready.
- axis_tlast  out  1  last beat of packet.
- axis_tkeep  out  AXIS_KEEP_WIDTH  constant all ones.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (resetn).
- Reset values:
  - state IDLE; axis_tvalid 0, axis_tlast 0, axis_tdata 0.
  - all accumulators 0; channel index 0; beat counter 0.
- States:
  - IDLE: tvalid 0.
  - RUN: tvalid 1.
  - IDLE->RUN when cfg_enable=1. tvalid rises the cycle after entry, with the first beat already registered.
  - RUN->IDLE only when the TLAST beat is accepted while cfg_enable=0. A stop request mid-packet therefore completes the packet.
- Handshake:
  - A beat transfers when tvalid & tready.
  - While tvalid=1 and tready=0, tdata and tlast hold stable. tvalid never drops mid-packet except on reset.
- Ordering:
  - A frame is NUM_CHANNELS beats, channel 0 first.
  - Beat for channel c in frame k carries wave(acc_c(k)).
  - acc_c(k+1) = acc_c(k) + inc_c, modulo 2^ACC_WIDTH (natural wrap).
  - A channel's accumulator advances only when that channel's beat is accepted.
- Config latching:
  - cfg_increment and cfg_waveform are captured on RUN entry and on acceptance of each channel NUM_CHANNELS-1 beat.
  - The captured values govern every beat of the next frame; changes mid-frame never split a frame.
  - cfg_enable is not latched.
- Waveforms (with top = acc[ACC_WIDTH-1 -: SAMPLE_WIDTH] and t = acc[ACC_WIDTH-2 -: SAMPLE_WIDTH]):
  - saw = top.
  - square = all ones if acc MSB=1, else 0.
  - triangle = ~t if acc MSB=1, else t.
  - silence = 0; accumulators still advance.
- TDATA formatting: sample zero-extended to AXIS_DATA_WIDTH.
- Packet:
  - Beat counter runs 0..PACKET_SIZE-1 on accepted beats and wraps to 0.
  - tlast=1 exactly on beat PACKET_SIZE-1.
  - Packets always start on channel 0.
- IDLE retention: accumulators and counters keep their values. Re-enable resumes phase continuity, starting at beat 0 of a new packet.
- Reset mid-packet: the packet is abandoned with no TLAST. Everything returns to reset values on the next clk edge.

Optional Feature:
- Macro: TONE_GEN_SIGNED_EN.
- Defined: sample converted to two's complement by inverting its MSB, then sign-extended to AXIS_DATA_WIDTH. Silence outputs 0, i.e. the signed midpoint.
- Undefined: unsigned offset-binary sample, zero-extended.

Test Plan:
1. Reset; NUM_CHANNELS=2, saw, inc0=0x01000000, inc1=0x02000000, tready=1, enable -> tdata 0x0000,0x0000,0x0100,0x0200,0x0200,0x0400,0x0300,0x0600...; tkeep=0xF.
2. Scenario 1 with random tready (50% low) -> identical accepted sequence; tdata/tlast stable during every stall; tvalid never drops.
3. PACKET_SIZE=8 -> tlast high only on accepted beats 7,15,23; beat 8 is channel 0.
4. Deassert cfg_enable after beat 3 accepted -> beats 4..7 delivered, tlast on beat 7, tvalid 0 next cycle. Re-enable -> saw continues from accumulator values held at the stop.
5. Switch to square with inc0=0x80000000 after ch0 beat of frame 2 is accepted -> ch1 of frame 2 still saw; from frame 3 ch0 alternates 0xFFFF/0x0000. Triangle at acc0=0xC0000000 -> ch0 sample 0x7FFF.
6. resetn low for 1 cycle at beat 5 -> tvalid 0, tdata 0 next edge. Re-enable -> first ch0 sample 0x0000, tlast on 8th accepted beat. With TONE_GEN_SIGNED_EN, sample 0x0000 reads 0xFFFF8000.
